// File: rtl/gravity_pkg.sv
// Shared types and default sizing for the gravity tick scheduler.
package gravity_pkg;

    localparam int TICK_CNT_W     = 8;
    localparam int DEF_LEVEL_W    = 4;
    localparam int DEF_MAX_LEVEL  = 9;
    localparam int DEF_BASE_TICKS = 20;
    localparam int DEF_STEP_TICKS = 2;
    localparam int DEF_SOFT_TICKS = 1;
    localparam int DEF_LOCK_TICKS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DROP_REQ,
        ST_LOCK_WAIT,
        ST_LOCK_REQ
    } state_e;

endpackage

// File: rtl/gravity_period_calc.sv
// Combinational fall period: clamps the level, applies soft drop and
// saturates the result so the period is never below one tick.
module gravity_period_calc
    import gravity_pkg::*;
#(
    parameter int LEVEL_W    = DEF_LEVEL_W,
    parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
    parameter int BASE_TICKS = DEF_BASE_TICKS,
    parameter int STEP_TICKS = DEF_STEP_TICKS,
    parameter int SOFT_TICKS = DEF_SOFT_TICKS
) (
    input  logic [LEVEL_W-1:0]    level,
    input  logic                  soft_drop,
    output logic [TICK_CNT_W-1:0] period
);

    function automatic logic [TICK_CNT_W-1:0] sat_period(input logic signed [8:0] raw);
        if (raw < 9'sd1) begin
            return TICK_CNT_W'(1);
        end
        return raw[TICK_CNT_W-1:0];
    endfunction

    logic [LEVEL_W-1:0] lvl;
    logic signed [8:0]  base_s;
    logic signed [8:0]  prod_s;
    logic signed [8:0]  raw_s;

    always_comb begin
        lvl = level;
        if (int'(level) > MAX_LEVEL) begin
            lvl = LEVEL_W'(MAX_LEVEL);
        end
        base_s = 9'(BASE_TICKS);
        prod_s = 9'(int'(lvl) * STEP_TICKS);
        raw_s  = base_s - prod_s;
        if (soft_drop) begin
            period = sat_period(9'(SOFT_TICKS));
        end else begin
            period = sat_period(raw_s);
        end
    end

endmodule

// File: rtl/gravity_tick_scheduler.sv
// Counts gravity ticks and issues fall/lock requests to the board FSM
// over req/ack handshakes.
module gravity_tick_scheduler
    import gravity_pkg::*;
#(
    parameter int LEVEL_W    = DEF_LEVEL_W,
    parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
    parameter int BASE_TICKS = DEF_BASE_TICKS,
    parameter int STEP_TICKS = DEF_STEP_TICKS,
    parameter int SOFT_TICKS = DEF_SOFT_TICKS,
    parameter int LOCK_TICKS = DEF_LOCK_TICKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  soft_drop,
    input  logic [LEVEL_W-1:0]    level,
    input  logic                  landed,
    output logic                  drop_req,
    input  logic                  drop_ack,
    output logic                  lock_req,
    input  logic                  lock_ack,
    output logic [TICK_CNT_W-1:0] tick_cnt,
    output logic                  overrun
);

    state_e                  state_q, state_d;
    logic [TICK_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    drop_req_q, drop_req_d;
    logic                    lock_req_q, lock_req_d;
    logic                    overrun_q, overrun_d;
    logic [TICK_CNT_W-1:0]   period;
    logic [TICK_CNT_W:0]     cnt_inc;
    logic                    tick_live;

    gravity_period_calc #(
        .LEVEL_W    (LEVEL_W),
        .MAX_LEVEL  (MAX_LEVEL),
        .BASE_TICKS (BASE_TICKS),
        .STEP_TICKS (STEP_TICKS),
        .SOFT_TICKS (SOFT_TICKS)
    ) u_period (
        .level     (level),
        .soft_drop (soft_drop),
        .period    (period)
    );

    assign cnt_inc   = {1'b0, cnt_q} + (TICK_CNT_W+1)'(1);
    assign tick_live = tick & ~pause;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
                ST_COUNT: begin
                    // landed wins over a same-cycle tick; >= lets a shrunken period fire at once
                    if (!pause) begin
                        if (landed) begin
                            state_d = ST_LOCK_WAIT;
                            cnt_d   = '0;
                        end else if (tick) begin
                            if (cnt_inc >= {1'b0, period}) begin
                                state_d = ST_DROP_REQ;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_inc[TICK_CNT_W-1:0];
                            end
                        end
                    end
                end
                ST_DROP_REQ: begin
                    if (tick_live) overrun_d = 1'b1;
                    if (drop_ack) state_d = ST_COUNT;
                end
                ST_LOCK_WAIT: begin
                    if (!pause) begin
                        if (!landed) begin
                            state_d = ST_COUNT;
                            cnt_d   = '0;
                        end else if (tick) begin
                            if (cnt_inc >= (TICK_CNT_W+1)'(LOCK_TICKS)) begin
                                state_d = ST_LOCK_REQ;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_inc[TICK_CNT_W-1:0];
                            end
                        end
                    end
                end
                ST_LOCK_REQ: begin
                    if (tick_live) overrun_d = 1'b1;
                    if (lock_ack) begin
                        state_d = ST_COUNT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // Requests are registered images of the next state, so they can never overlap
        drop_req_d = (state_d == ST_DROP_REQ);
        lock_req_d = (state_d == ST_LOCK_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drop_req_q <= 1'b0;
            lock_req_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_req_q <= drop_req_d;
            lock_req_q <= lock_req_d;
            overrun_q  <= overrun_d;
        end
    end

    assign drop_req = drop_req_q;
    assign lock_req = lock_req_q;
    assign tick_cnt = cnt_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_gravity_tick_scheduler.sv
// Directed bench for gravity_tick_scheduler; a second instance uses a
// steeper level step to exercise period saturation.
module tb_gravity_tick_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       enable;
    logic       pause;
    logic       soft_drop;
    logic [3:0] level;
    logic       landed;
    logic       drop_ack;
    logic       lock_ack;

    logic       drop_req, lock_req, overrun;
    logic [7:0] tick_cnt;
    logic       drop_req2, lock_req2, overrun2;
    logic [7:0] tick_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gravity_tick_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enable    (enable),
        .pause     (pause),
        .soft_drop (soft_drop),
        .level     (level),
        .landed    (landed),
        .drop_req  (drop_req),
        .drop_ack  (drop_ack),
        .lock_req  (lock_req),
        .lock_ack  (lock_ack),
        .tick_cnt  (tick_cnt),
        .overrun   (overrun)
    );

    gravity_tick_scheduler #(.STEP_TICKS(3)) dut_steep (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enable    (enable),
        .pause     (pause),
        .soft_drop (soft_drop),
        .level     (level),
        .landed    (landed),
        .drop_req  (drop_req2),
        .drop_ack  (drop_ack),
        .lock_req  (lock_req2),
        .lock_ack  (lock_ack),
        .tick_cnt  (tick_cnt2),
        .overrun   (overrun2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; enable = 1'b0; pause = 1'b0; soft_drop = 1'b0;
        level = 4'd0; landed = 1'b0; drop_ack = 1'b0; lock_ack = 1'b0;
        #3;
        check("rst_cnt", tick_cnt, 0);
        check("rst_drop", drop_req, 0);
        check("rst_lock", lock_req, 0);
        check("rst_ovr", overrun, 0);

        step();
        rst = 1'b0; enable = 1'b1; drop_ack = 1'b1;
        step();
        step();

        // level 0: period 20
        ticks(19);
        check("l0_cnt19", tick_cnt, 19);
        check("l0_nodrop19", drop_req, 0);
        pulse_tick();
        check("l0_drop20", drop_req, 1);
        check("l0_cnt0", tick_cnt, 0);
        step();
        check("l0_drop_1cyc", drop_req, 0);
        check("l0_ovr", overrun, 0);

        // level 12 clamps to 9: period 2; steep instance saturates to 1
        level = 4'd12;
        pulse_tick();
        check("l12_cnt1", tick_cnt, 1);
        check("l12_nodrop1", drop_req, 0);
        check("sat_drop1", drop_req2, 1);
        pulse_tick();
        check("l12_drop2", drop_req, 1);
        check("sat_ack", drop_req2, 0);
        step();
        check("l12_drop_done", drop_req, 0);
        pulse_tick();
        check("l12_nodrop3", drop_req, 0);
        check("sat_drop3", drop_req2, 1);
        pulse_tick();
        check("l12_drop4", drop_req, 1);
        step();

        // soft drop mid-count
        level = 4'd0;
        ticks(5);
        check("sd_cnt5", tick_cnt, 5);
        soft_drop = 1'b1;
        pulse_tick();
        check("sd_drop", drop_req, 1);
        soft_drop = 1'b0;
        step();
        check("sd_done", drop_req, 0);

        // ack withheld across 3 ticks
        drop_ack = 1'b0;
        ticks(20);
        check("wh_drop", drop_req, 1);
        ticks(3);
        check("wh_drop_held", drop_req, 1);
        check("wh_ovr", overrun, 1);
        check("wh_cnt", tick_cnt, 0);
        drop_ack = 1'b1;
        step();
        check("wh_released", drop_req, 0);
        pulse_tick();
        check("wh_count", tick_cnt, 1);
        check("wh_ovr_sticky", overrun, 1);
        enable = 1'b0;
        step();
        check("dis_ovr", overrun, 0);
        check("dis_cnt", tick_cnt, 0);
        enable = 1'b1;
        step();

        // landed -> lock after 10 ticks
        landed = 1'b1;
        step();
        ticks(9);
        check("lk_cnt9", tick_cnt, 9);
        check("lk_nolock9", lock_req, 0);
        pulse_tick();
        check("lk_lock", lock_req, 1);
        check("lk_nodrop", drop_req, 0);
        lock_ack = 1'b1;
        step();
        check("lk_done", lock_req, 0);
        check("lk_cnt0", tick_cnt, 0);
        landed = 1'b0; lock_ack = 1'b0;
        step();

        // piece slides off after 4 ticks
        landed = 1'b1;
        step();
        ticks(4);
        check("sl_cnt4", tick_cnt, 4);
        landed = 1'b0;
        step();
        check("sl_cnt0", tick_cnt, 0);
        ticks(6);
        check("sl_cnt6", tick_cnt, 6);
        check("sl_nolock", lock_req, 0);

        // pause while drop_req outstanding
        drop_ack = 1'b0;
        ticks(14);
        check("pz_drop", drop_req, 1);
        pause = 1'b1;
        ticks(3);
        check("pz_ovr", overrun, 0);
        check("pz_held", drop_req, 1);
        drop_ack = 1'b1;
        step();
        check("pz_acked", drop_req, 0);
        drop_ack = 1'b0;
        ticks(3);
        check("pz_frozen", tick_cnt, 0);
        pause = 1'b0;
        pulse_tick();
        check("pz_resume", tick_cnt, 1);

        // async reset during lock_req
        landed = 1'b1;
        step();
        ticks(10);
        check("ar_lock", lock_req, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_lock0", lock_req, 0);
        check("ar_drop0", drop_req, 0);
        check("ar_cnt0", tick_cnt, 0);
        check("ar_ovr0", overrun, 0);
        landed = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();

        // enable low returns to IDLE; IDLE does not count
        ticks(3);
        check("en_cnt3", tick_cnt, 3);
        enable = 1'b0;
        step();
        check("en_cnt0", tick_cnt, 0);
        pulse_tick();
        check("en_idle", tick_cnt, 0);
        enable = 1'b1;
        step();
        pulse_tick();
        check("en_restart", tick_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
